conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
- Sequences one feature-map frame through a streaming 3x3 conv layer (line buffers, window generators, MAC array, GELU).
- Generates frame-memory read addresses and the conv layer's in_valid strobe, aligned to the memory read latency.
- Appends zero "flush" pixels so the line buffers drain the last rows, then counts conv output beats and signals frame completion.
- Sits between the layer's input feature-map buffer and the conv layer; one instance per conv layer.

Parameters:
- IMG_W, 28, frame width in pixels
- IMG_H, 28, frame height in pixels
- MEM_LAT, 1, frame-memory read latency in cycles (1..4)
- FLUSH_PIX, 29, zero pixels appended after the last real pixel (IMG_W+1 for 3x3, padding 1)
- OUT_CNT, 784, conv output beats expected per frame
- DRAIN_MAX, 255, max cycles to wait in DRAIN before timeout
- ADDR_W, 10, read address width (>= clog2(IMG_W*IMG_H))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start request
- ds_ready  in  1  downstream can accept another output row
- conv_out_valid  in  1  conv layer output-beat strobe
- mem_rd_en  out  1  frame-memory read enable
- mem_rd_addr  out  ADDR_W  read address, row-major (row*IMG_W+col)
- conv_in_valid  out  1  conv layer in_valid, aligned with returned memory data
- zero_sel  out  1  data mux select: 1 = drive zero into conv inputs (flush pixel)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at frame end
- err_timeout  out  1  sticky: DRAIN timed out; cleared by the next accepted start
- out_cnt  out  clog2(OUT_CNT+1)  conv output beats counted this frame, saturating

Behaviour:
- Reset: all outputs 0, FSM = IDLE, all counters 0.
- FSM states: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 → FEED; clear out_cnt and err_timeout; busy=1 next cycle.
  - start in any state other than IDLE is ignored.
- FEED:
  - Issue mem_rd_en=1 with mem_rd_addr 0,1,2,… one per cycle; col/row counters track the issued pixel.
  - After issuing col==IMG_W-1: if ds_ready=0, pause. No issue until ds_ready=1; resume at col 0 of the next row.
  - ds_ready is sampled only at row boundaries.
  - After issuing addr IMG_W*IMG_H-1 → FLUSH, with no row-boundary pause.
- FLUSH:
  - FLUSH_PIX cycles of a zero pixel: mem_rd_en=0, internal issue strobe=1, zero flag=1. No pausing.
  - Then → DRAIN.
- Alignment:
  - conv_in_valid = issue strobe delayed MEM_LAT cycles.
  - zero_sel = zero flag delayed MEM_LAT cycles.
  - Both go through the same shift register, so a real pixel never carries zero_sel=1.
- DRAIN:
  - Wait until out_cnt==OUT_CNT and the delay pipe is empty → DONE.
  - Wait counter starts at 0 on entry; if it reaches DRAIN_MAX first, set err_timeout=1 → DONE.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- out_cnt:
  - Increments on conv_out_valid in FEED/FLUSH/DRAIN/DONE.
  - Saturates at OUT_CNT; extra beats are ignored.
  - Beats in IDLE are ignored.
- Async reset mid-frame: everything returns to reset values immediately, with no done pulse. The conv layer must be reset alongside it.

Optional Feature:
- Macro: CONV_SEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles (16 bits, saturating): counts FEED cycles spent paused on ds_ready=0.
  - Adds output frame_cycles (24 bits, saturating): counts busy cycles.
  - Both clear on an accepted start and hold after done.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=3, MEM_LAT=1, FLUSH_PIX=5, OUT_CNT=12, ds_ready=1, conv model returns 12 beats:
  - mem_rd_addr 0..11 on consecutive cycles.
  - conv_in_valid high 17 consecutive cycles starting 1 cycle after the first rd_en; last 5 with zero_sel=1.
  - done pulse once, out_cnt=12, err_timeout=0.
- Same config, ds_ready=0 for 3 cycles at the end of row 0:
  - Issue pauses after addr 3 and resumes with addr 4 one cycle after ds_ready rises.
  - Total busy time grows by 3 cycles; with CONV_SEQ_PERF_EN, stall_cycles=3.
- Conv model returns only 10 beats, DRAIN_MAX=20:
  - done asserts 20 cycles after DRAIN entry, err_timeout=1, out_cnt=10.
  - Next start clears err_timeout.
- 14 conv_out_valid beats with OUT_CNT=12: out_cnt holds 12; start pulsed mid-frame has no effect on addresses.
- rst_n low for 2 cycles at addr 6:
  - All outputs 0 asynchronously, FSM in IDLE, no done pulse.
  - A new start restarts from addr 0.
- MEM_LAT=3: conv_in_valid and zero_sel are exactly the issue and zero strobes delayed by 3 cycles.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Sequences one frame through a streaming 3x3 conv layer: row-major reads, zero flush pixels,
// output-beat counting. Define CONV_SEQ_PERF_EN to add stall_cycles/frame_cycles counters.
module conv_frame_sequencer #(
    parameter int unsigned IMG_W     = 28,
    parameter int unsigned IMG_H     = 28,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned FLUSH_PIX = 29,
    parameter int unsigned OUT_CNT   = 784,
    parameter int unsigned DRAIN_MAX = 255,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         ds_ready,
    input  logic                         conv_out_valid,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    output logic                         conv_in_valid,
    output logic                         zero_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         err_timeout,
    output logic [$clog2(OUT_CNT+1)-1:0] out_cnt
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [15:0]                  stall_cycles,
    output logic [23:0]                  frame_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(OUT_CNT + 1);
    localparam int unsigned COL_W = $clog2(IMG_W + 1);
    localparam int unsigned ROW_W = $clog2(IMG_H + 1);
    localparam int unsigned FL_W  = $clog2(FLUSH_PIX + 1);
    localparam int unsigned WT_W  = $clog2(DRAIN_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_PIX - 1);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUT_CNT);

    typedef enum logic [2:0] {StIdle, StFeed, StFlush, StDrain, StDone} state_e;

    state_e                    state_q;
    logic                      issue_q;
    logic                      zero_q;
    logic [COL_W-1:0]          col_q;
    logic [ROW_W-1:0]          row_q;
    logic [FL_W-1:0]           flush_q;
    logic [WT_W-1:0]           wait_q;
    // Bit 1 = issue strobe, bit 0 = zero flag; shared so the two can never drift apart.
    logic [MEM_LAT-1:0][1:0]   pipe_q;
    logic                      pipe_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {issue_q, zero_q};
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            pipe_busy = pipe_busy | pipe_q[i][1];
        end
    end

    assign conv_in_valid = pipe_q[MEM_LAT-1][1];
    assign zero_sel      = pipe_q[MEM_LAT-1][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            issue_q      <= 1'b0;
            zero_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            flush_q      <= '0;
            wait_q       <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            out_cnt      <= '0;
`ifdef CONV_SEQ_PERF_EN
            stall_cycles <= '0;
            frame_cycles <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state_q != StIdle && conv_out_valid && out_cnt != CNT_MAX) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
`ifdef CONV_SEQ_PERF_EN
            if (busy && frame_cycles != '1) frame_cycles <= frame_cycles + 24'd1;
            if (state_q == StFeed && !mem_rd_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StFeed;
                        busy         <= 1'b1;
                        mem_rd_en    <= 1'b1;
                        issue_q      <= 1'b1;
                        mem_rd_addr  <= '0;
                        col_q        <= '0;
                        row_q        <= '0;
                        out_cnt      <= '0;
                        err_timeout  <= 1'b0;
`ifdef CONV_SEQ_PERF_EN
                        stall_cycles <= '0;
                        frame_cycles <= '0;
`endif
                    end
                end
                StFeed: begin
                    if (mem_rd_en) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                // Last real pixel: flush follows immediately, no row pause.
                                state_q   <= StFlush;
                                mem_rd_en <= 1'b0;
                                zero_q    <= 1'b1;
                                flush_q   <= '0;
                            end else begin
                                row_q       <= row_q + ROW_W'(1);
                                mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                                if (!ds_ready) begin
                                    mem_rd_en <= 1'b0;
                                    issue_q   <= 1'b0;
                                end
                            end
                        end else begin
                            col_q       <= col_q + COL_W'(1);
                            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                        end
                    end else if (ds_ready) begin
                        mem_rd_en <= 1'b1;
                        issue_q   <= 1'b1;
                    end
                end
                StFlush: begin
                    if (flush_q == FL_LAST) begin
                        state_q <= StDrain;
                        issue_q <= 1'b0;
                        zero_q  <= 1'b0;
                        wait_q  <= '0;
                    end else begin
                        flush_q <= flush_q + FL_W'(1);
                    end
                end
                StDrain: begin
                    if (out_cnt == CNT_MAX && !pipe_busy) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else if (wait_q == WT_LAST) begin
                        state_q     <= StDone;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer: 4x3 frame, 5 flush pixels, DUTs at MEM_LAT 1 and 3.
module tb_conv_frame_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ds_ready = 1'b1;
    logic conv_out_valid;

    logic          rd_en_a, civ_a, zs_a, busy_a, done_a, err_a;
    logic [AW-1:0] addr_a;
    logic [CW-1:0] cnt_a;
    logic          rd_en_b, civ_b, zs_b, busy_b, done_b, err_b;
    logic [AW-1:0] addr_b;
    logic [CW-1:0] cnt_b;
`ifdef CONV_SEQ_PERF_EN
    logic [15:0] stall_a, stall_b;
    logic [23:0] fc_a, fc_b;
`endif

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .IMG_W(4), .IMG_H(3), .MEM_LAT(1), .FLUSH_PIX(5), .OUT_CNT(12), .DRAIN_MAX(20),
        .ADDR_W(AW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .ds_ready(ds_ready),
        .conv_out_valid(conv_out_valid), .mem_rd_en(rd_en_a), .mem_rd_addr(addr_a),
        .conv_in_valid(civ_a), .zero_sel(zs_a), .busy(busy_a), .done(done_a),
        .err_timeout(err_a), .out_cnt(cnt_a)
`ifdef CONV_SEQ_PERF_EN
        , .stall_cycles(stall_a), .frame_cycles(fc_a)
`endif
    );

    conv_frame_sequencer #(
        .IMG_W(4), .IMG_H(3), .MEM_LAT(3), .FLUSH_PIX(5), .OUT_CNT(12), .DRAIN_MAX(20),
        .ADDR_W(AW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .ds_ready(ds_ready),
        .conv_out_valid(conv_out_valid), .mem_rd_en(rd_en_b), .mem_rd_addr(addr_b),
        .conv_in_valid(civ_b), .zero_sel(zs_b), .busy(busy_b), .done(done_b),
        .err_timeout(err_b), .out_cnt(cnt_b)
`ifdef CONV_SEQ_PERF_EN
        , .stall_cycles(stall_b), .frame_cycles(fc_b)
`endif
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Conv layer stand-in: one output beat 3 cycles after each input beat, capped per frame.
    logic [2:0]  cv_sh = 3'b000;
    int unsigned beats_sent = 0;
    int unsigned beat_target = 12;
    assign conv_out_valid = cv_sh[2] && (beats_sent < beat_target);
    always @(posedge clk) begin
        cv_sh <= {cv_sh[1:0], civ_a};
        if (start && !busy_a) beats_sent <= 0;
        else if (conv_out_valid) beats_sent <= beats_sent + 1;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int unsigned val;
        int unsigned cyc;
    } ev_t;
    typedef struct {
        int unsigned cnt;
        int unsigned err;
        int unsigned cyc;
        int unsigned busy;
        int unsigned stall;
    } dn_t;

    ev_t q_rd[$];
    ev_t q_civ_a[$];
    ev_t q_civ_b[$];
    dn_t q_done[$];

    int unsigned busy_run = 0;
    int unsigned n_done = 0;
    int unsigned exp_done = 0;

    always @(negedge clk) begin
        ev_t e;
        dn_t d;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy_a) busy_run = busy_run + 1;
            if (rd_en_a) begin
                if (q_rd.size() == 0) check("rd_en unexpected (queue depth)", q_rd.size(), 1);
                else begin
                    e = q_rd.pop_front();
                    check("rd_addr", addr_a, e.val);
                    check("rd_cycle", cyc, e.cyc);
                end
            end
            if (civ_a) begin
                if (q_civ_a.size() == 0) check("civ_a unexpected (queue depth)", q_civ_a.size(), 1);
                else begin
                    e = q_civ_a.pop_front();
                    check("civ_a zero_sel", zs_a, e.val);
                    check("civ_a cycle", cyc, e.cyc);
                end
            end
            if (civ_b) begin
                if (q_civ_b.size() == 0) check("civ_b unexpected (queue depth)", q_civ_b.size(), 1);
                else begin
                    e = q_civ_b.pop_front();
                    check("civ_b zero_sel", zs_b, e.val);
                    check("civ_b cycle", cyc, e.cyc);
                end
            end
            if (done_a) begin
                n_done++;
                if (q_done.size() == 0) check("done unexpected (queue depth)", q_done.size(), 1);
                else begin
                    d = q_done.pop_front();
                    check("done out_cnt", cnt_a, d.cnt);
                    check("done err_timeout", err_a, d.err);
                    check("done busy", busy_a, 0);
                    if (d.cyc != 0) check("done cycle", cyc, d.cyc);
                    check("busy cycles", busy_run, d.busy);
`ifdef CONV_SEQ_PERF_EN
                    check("stall_cycles", stall_a, d.stall);
                    check("frame_cycles", fc_a, d.busy);
`endif
                end
                busy_run = 0;
            end
        end
    end

    task automatic goto_cyc(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected schedule: 12 reads then 5 flush issues, shifted by any row-0 stall.
    task automatic push_frame(input int unsigned t0, input int unsigned stall,
                              input int unsigned cutoff);
        int unsigned c;
        for (int unsigned i = 0; i < 17; i++) begin
            c = t0 + 1 + i + ((i >= 4) ? stall : 0);
            if (i < 12 && c <= cutoff) q_rd.push_back('{val: i, cyc: c});
            if (c + 1 <= cutoff) q_civ_a.push_back('{val: (i >= 12) ? 1 : 0, cyc: c + 1});
            if (c + 3 <= cutoff) q_civ_b.push_back('{val: (i >= 12) ? 1 : 0, cyc: c + 3});
        end
    endtask

    task automatic start_frame(input int unsigned target, input int unsigned stall,
                               input int unsigned cut_rel, input bit want_done,
                               input dn_t d, output int unsigned t0);
        dn_t dd;
        beat_target = target;
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        push_frame(t0, stall, (cut_rel != 0) ? t0 + cut_rel : 32'hffff_ffff);
        if (want_done) begin
            dd = d;
            if (d.cyc != 0) dd.cyc = t0 + d.cyc;
            q_done.push_back(dd);
            exp_done++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned prev;
        bit got;
        prev = n_done;
        got = 1'b0;
        for (int unsigned k = 0; k < budget && !got; k++) begin
            @(posedge clk);
            #2;
            if (n_done != prev) got = 1'b1;
        end
        check("done within budget", got, 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned t0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_en", rd_en_a, 0);
        check("reset addr", addr_a, 0);
        check("reset civ", civ_a, 0);
        check("reset zero_sel", zs_a, 0);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset err", err_a, 0);
        check("reset out_cnt", cnt_a, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame.
        start_frame(12, 0, 0, 1'b1, '{cnt: 12, err: 0, cyc: 0, busy: 19, stall: 0}, t0);
        wait_done(60);

        // ds_ready low for 3 cycles at the end of row 0.
        start_frame(12, 3, 0, 1'b1, '{cnt: 12, err: 0, cyc: 0, busy: 22, stall: 3}, t0);
        goto_cyc(t0 + 4);
        ds_ready = 1'b0;
        goto_cyc(t0 + 7);
        ds_ready = 1'b1;
        wait_done(60);

        // Only 10 beats: DRAIN entered at t0+18, timeout 20 cycles later.
        start_frame(10, 0, 0, 1'b1, '{cnt: 10, err: 1, cyc: 38, busy: 37, stall: 0}, t0);
        wait_done(80);
        check("err_timeout sticky", err_a, 1);
        check("out_cnt holds after done", cnt_a, 10);

        // 14 beats saturate at 12; mid-frame start ignored; start clears err_timeout.
        start_frame(14, 0, 0, 1'b1, '{cnt: 12, err: 0, cyc: 0, busy: 19, stall: 0}, t0);
        check("err cleared by start", err_a, 0);
        goto_cyc(t0 + 5);
        start = 1'b1;
        goto_cyc(t0 + 6);
        start = 1'b0;
        wait_done(60);

        // Async reset just after addr 6 is presented.
        start_frame(12, 0, 7, 1'b0, '{cnt: 0, err: 0, cyc: 0, busy: 0, stall: 0}, t0);
        goto_cyc(t0 + 7);
        #6;
        rst_n = 1'b0;
        #1;
        check("async rst rd_en", rd_en_a, 0);
        check("async rst addr", addr_a, 0);
        check("async rst civ", civ_a, 0);
        check("async rst busy", busy_a, 0);
        check("async rst out_cnt", cnt_a, 0);
        check("async rst civ_b", civ_b, 0);
        check("async rst busy_b", busy_b, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no done after reset", n_done, exp_done);

        // Restart from addr 0.
        start_frame(12, 0, 0, 1'b1, '{cnt: 12, err: 0, cyc: 0, busy: 19, stall: 0}, t0);
        wait_done(60);

        check("leftover rd", q_rd.size(), 0);
        check("leftover civ_a", q_civ_a.size(), 0);
        check("leftover civ_b", q_civ_b.size(), 0);
        check("leftover done", q_done.size(), 0);
        check("done pulse count", n_done, exp_done);
        check("b idle at end", busy_b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
